// File: rtl/ecc_hamming_pkg.sv
// -----------------------------------------------------------------------------
// ecc_hamming_pkg
// Shared Hamming SECDED helpers used by both the encoder and the decoder.
//   parity_bits(d)          : number of Hamming parity bits needed for d data bits
//   is_pow2(pos)            : true when a Hamming position holds a parity bit
//   data_pos(i)             : Hamming position (1-based) of data bit i
//   syndrome_calc(cw, c, k) : bit k of the syndrome of a c-bit codeword
// Codewords are passed zero-extended to MAX_C bits so one function body
// serves every codeword width up to MAX_C-1.
// -----------------------------------------------------------------------------
package ecc_hamming_pkg;

    localparam int MAX_C = 64;

    function automatic int parity_bits(input int d);
        int p;
        p = 32'sd0;
        for (int k = 1; k < 32; k++) begin
            if ((p == 32'sd0) && ((32'sd1 << k) >= (d + k + 32'sd1))) begin
                p = k;
            end
        end
        return p;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 32'sd0) && ((pos & (pos - 32'sd1)) == 32'sd0);
    endfunction

    // Data bits fill the non-power-of-two positions in ascending order,
    // so data bit 0 lands at position 3.
    function automatic int data_pos(input int i);
        int pos;
        int cnt;
        pos = 32'sd0;
        cnt = 32'sd0;
        for (int p = 1; p <= MAX_C; p++) begin
            if (!is_pow2(p)) begin
                if ((cnt == i) && (pos == 32'sd0)) begin
                    pos = p;
                end
                cnt = cnt + 32'sd1;
            end
        end
        return pos;
    endfunction

    // Syndrome bit k is the parity of all set codeword bits whose position
    // index has bit k set; together the bits form the XOR of set positions.
    function automatic logic syndrome_calc(input logic [MAX_C-1:0] cw, input int c, input int k);
        logic b;
        b = 1'b0;
        for (int pos = 1; pos <= MAX_C; pos++) begin
            if ((pos <= c) && (((pos >> k) & 32'sd1) == 32'sd1) && cw[pos-1]) begin
                b = ~b;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ecc_hamming_syndrome.sv
// -----------------------------------------------------------------------------
// ecc_hamming_syndrome
// Combinational syndrome and overall-parity generator.
//   codeword     in  C  received codeword (position pos at codeword[pos-1])
//   extra_parity in  1  received overall (even) parity bit
//   syndrome     out P  XOR of the position indices of all set codeword bits
//   overall      out 1  parity of codeword and extra_parity; 1 = odd error count
// -----------------------------------------------------------------------------
module ecc_hamming_syndrome
    import ecc_hamming_pkg::*;
#(
    parameter int C = 7,
    parameter int P = 3
) (
    input  logic [C-1:0] codeword,
    input  logic         extra_parity,
    output logic [P-1:0] syndrome,
    output logic         overall
);

    for (genvar k = 0; k < P; k++) begin : g_syn
        assign syndrome[k] = syndrome_calc({{(MAX_C - C){1'b0}}, codeword}, C, k);
    end

    assign overall = (^codeword) ^ extra_parity;

endmodule

// File: rtl/ecc_hamming_secded_pipe_decoder.sv
// -----------------------------------------------------------------------------
// ecc_hamming_secded_pipe_decoder
// Two-stage pipelined Hamming SECDED decoder with valid/ready flow control and
// saturating statistics counters.
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           input handshake (in_ready is combinational)
//   codeword[C], extra_parity   received codeword and overall parity bit
//   out_valid/out_ready         output handshake
//   dout[D]                     data, corrected when possible
//   error_single_bit            single error detected and corrected
//   error_double_bit            uncorrectable error detected
//   syndrome[P]                 raw syndrome of the delivered word
//   cnt_clear                   zeroes both counters (beats same-cycle increment)
//   corr_cnt/uncorr_cnt[CNT_W]  saturating counts of delivered flagged words
// Stage 1 holds codeword/syndrome/overall; stage 2 holds the decoded result.
// -----------------------------------------------------------------------------
module ecc_hamming_secded_pipe_decoder
    import ecc_hamming_pkg::*;
#(
    parameter int D     = 4,
    parameter int C     = 7,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [C-1:0]     codeword,
    input  logic             extra_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D-1:0]     dout,
    output logic             error_single_bit,
    output logic             error_double_bit,
    output logic [C-D-1:0]   syndrome,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam int P = C - D;

    logic             s1_valid_r;
    logic [C-1:0]     s1_cw_r;
    logic [P-1:0]     s1_syn_r;
    logic             s1_overall_r;

    logic             s2_valid_r;
    logic [D-1:0]     s2_dout_r;
    logic             s2_sb_r;
    logic             s2_db_r;
    logic [P-1:0]     s2_syn_r;

    logic [CNT_W-1:0] corr_cnt_r;
    logic [CNT_W-1:0] uncorr_cnt_r;

    logic [P-1:0]     syn_s;
    logic             overall_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             out_fire_s;
    logic [C-1:0]     flip_s;
    logic [C-1:0]     cw_fix_s;
    logic [D-1:0]     data_s;
    logic             sb_s;
    logic             db_s;

    ecc_hamming_syndrome #(
        .C (C),
        .P (P)
    ) u_syndrome (
        .codeword     (codeword),
        .extra_parity (extra_parity),
        .syndrome     (syn_s),
        .overall      (overall_s)
    );

    assign s1_adv_s   = !s2_valid_r || out_ready;
    assign in_ready_s = !s1_valid_r || s1_adv_s;
    assign out_fire_s = s2_valid_r && out_ready;

    // One-hot mask of the position named by the stage-1 syndrome (zero when
    // the syndrome is 0 or points beyond the codeword).
    for (genvar pos = 1; pos <= C; pos++) begin : g_flip
        assign flip_s[pos-1] = (s1_syn_r == P'(pos));
    end

    // Classify the stage-1 word and build the corrected codeword.
    always_comb begin
        cw_fix_s = s1_cw_r;
        sb_s     = 1'b0;
        db_s     = 1'b0;
        if (s1_overall_r) begin
            if (s1_syn_r == {P{1'b0}}) begin
                // Only the extra parity bit is wrong; data is intact.
                sb_s = 1'b1;
            end else if (s1_syn_r <= P'(C)) begin
                sb_s     = 1'b1;
                cw_fix_s = s1_cw_r ^ flip_s;
            end else begin
                // Syndrome names a position that does not exist.
                db_s = 1'b1;
            end
        end else begin
            if (s1_syn_r != {P{1'b0}}) begin
                db_s = 1'b1;
            end else begin
                db_s = 1'b0;
            end
        end
    end

    // Pull the data bits out of their Hamming positions.
    for (genvar i = 0; i < D; i++) begin : g_data
        localparam int DPOS = data_pos(i);
        assign data_s[i] = cw_fix_s[DPOS-1];
    end

    // Stage 1 register: codeword with its syndrome and overall parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_cw_r      <= {C{1'b0}};
            s1_syn_r     <= {P{1'b0}};
            s1_overall_r <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_cw_r      <= codeword;
                s1_syn_r     <= syn_s;
                s1_overall_r <= overall_s;
            end
        end
    end

    // Stage 2 register: decoded payload, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_dout_r  <= {D{1'b0}};
            s2_sb_r    <= 1'b0;
            s2_db_r    <= 1'b0;
            s2_syn_r   <= {P{1'b0}};
        end else if (s1_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_dout_r <= data_s;
                s2_sb_r   <= sb_s;
                s2_db_r   <= db_s;
                s2_syn_r  <= s1_syn_r;
            end
        end
    end

    // Saturating statistics counters, bumped on delivery; clear wins.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            corr_cnt_r   <= {CNT_W{1'b0}};
            uncorr_cnt_r <= {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            if (s2_sb_r && (corr_cnt_r != {CNT_W{1'b1}})) begin
                corr_cnt_r <= corr_cnt_r + CNT_W'(1);
            end
            if (s2_db_r && (uncorr_cnt_r != {CNT_W{1'b1}})) begin
                uncorr_cnt_r <= uncorr_cnt_r + CNT_W'(1);
            end
        end
    end

    assign in_ready         = in_ready_s;
    assign out_valid        = s2_valid_r;
    assign dout             = s2_dout_r;
    assign error_single_bit = s2_sb_r;
    assign error_double_bit = s2_db_r;
    assign syndrome         = s2_syn_r;
    assign corr_cnt         = corr_cnt_r;
    assign uncorr_cnt       = uncorr_cnt_r;

endmodule

// File: tb/tb_ecc_hamming_secded_pipe_decoder.sv
// -----------------------------------------------------------------------------
// tb_ecc_hamming_secded_pipe_decoder
// Directed bench for the pipelined SECDED decoder, D=4, C=7, CNT_W=2.
// Expected values are hand-computed Hamming(7,4) results.
// -----------------------------------------------------------------------------
module tb_ecc_hamming_secded_pipe_decoder;

    localparam int D     = 4;
    localparam int C     = 7;
    localparam int P     = 3;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [C-1:0]     codeword;
    logic             extra_parity;
    logic             out_valid;
    logic             out_ready;
    logic [D-1:0]     dout;
    logic             error_single_bit;
    logic             error_double_bit;
    logic [P-1:0]     syndrome;
    logic             cnt_clear;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int checks;
    int errors;
    int exp_corr;
    int exp_unc;

    ecc_hamming_secded_pipe_decoder #(
        .D     (D),
        .C     (C),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .codeword         (codeword),
        .extra_parity     (extra_parity),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .dout             (dout),
        .error_single_bit (error_single_bit),
        .error_double_bit (error_double_bit),
        .syndrome         (syndrome),
        .cnt_clear        (cnt_clear),
        .corr_cnt         (corr_cnt),
        .uncorr_cnt       (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Push one word through an idle pipeline with out_ready=1 and check it.
    task automatic run_word(input logic [6:0] cw, input logic ep, input logic [3:0] ed,
                            input logic esb, input logic edb, input logic [2:0] esyn,
                            input logic clr);
        @(negedge clk);
        in_valid     = 1'b1;
        codeword     = cw;
        extra_parity = ep;
        check_val("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("lat_s1", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("out_valid", 32'(out_valid), 32'd1);
        check_val("dout", 32'(dout), 32'(ed));
        check_val("err_sb", 32'(error_single_bit), 32'(esb));
        check_val("err_db", 32'(error_double_bit), 32'(edb));
        check_val("syndrome", 32'(syndrome), 32'(esyn));
        cnt_clear = clr;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        if (clr) begin
            exp_corr = 0;
            exp_unc  = 0;
        end else begin
            if (esb && (exp_corr < 3)) exp_corr++;
            if (edb && (exp_unc < 3)) exp_unc++;
        end
        check_val("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
        check_val("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_unc));
        check_val("drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_corr     = 0;
        exp_unc      = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        codeword     = 7'h00;
        extra_parity = 1'b0;
        out_ready    = 1'b1;
        cnt_clear    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_dout", 32'(dout), 32'd0);
        check_val("rst_flags", 32'({error_single_bit, error_double_bit}), 32'd0);
        check_val("rst_syndrome", 32'(syndrome), 32'd0);
        check_val("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);

        //        cw     ep    dout  sb    db    syn   clr
        run_word(7'h55, 1'b0, 4'hB, 1'b0, 1'b0, 3'd0, 1'b0); // clean
        run_word(7'h45, 1'b0, 4'hB, 1'b1, 1'b0, 3'd5, 1'b0); // pos 5 flipped
        run_word(7'h56, 1'b0, 4'hB, 1'b0, 1'b1, 3'd3, 1'b0); // pos 1,2 flipped
        run_word(7'h55, 1'b1, 4'hB, 1'b1, 1'b0, 3'd0, 1'b0); // extra parity wrong
        run_word(7'h00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0); // clean, din=0
        run_word(7'h7F, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 1'b0); // clean, din=F
        run_word(7'h7E, 1'b1, 4'hF, 1'b1, 1'b0, 3'd1, 1'b0); // pos 1 flipped
        run_word(7'h6B, 1'b1, 4'hC, 1'b0, 1'b1, 3'd6, 1'b0); // pos 3,5 flipped

        // Backpressure: three clean words with the consumer stalled.
        @(negedge clk);
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        codeword     = 7'h55;
        extra_parity = 1'b0;
        #1;
        check_val("bp_acc0", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        codeword     = 7'h7F;
        extra_parity = 1'b1;
        check_val("bp_acc1", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        codeword     = 7'h00;
        extra_parity = 1'b0;
        check_val("bp_full", 32'(in_ready), 32'd0);
        check_val("bp_ov0", 32'(out_valid), 32'd1);
        check_val("bp_dout0", 32'(dout), 32'hB);
        @(posedge clk);
        @(negedge clk);
        check_val("bp_full2", 32'(in_ready), 32'd0);
        check_val("bp_hold", 32'(dout), 32'hB);
        check_val("bp_hold_ov", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check_val("bp_pass", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("bp_ov1", 32'(out_valid), 32'd1);
        check_val("bp_dout1", 32'(dout), 32'hF);
        @(posedge clk);
        @(negedge clk);
        check_val("bp_ov2", 32'(out_valid), 32'd1);
        check_val("bp_dout2", 32'(dout), 32'h0);
        check_val("bp_syn2", 32'(syndrome), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("bp_empty", 32'(out_valid), 32'd0);
        check_val("bp_cnts", 32'(corr_cnt), 32'(exp_corr));

        // Saturation: clear, then five corrected words on a 2-bit counter.
        @(negedge clk);
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        exp_corr  = 0;
        exp_unc   = 0;
        check_val("clr_corr", 32'(corr_cnt), 32'd0);
        check_val("clr_unc", 32'(uncorr_cnt), 32'd0);
        for (int n = 0; n < 5; n++) begin
            run_word(7'h45, 1'b0, 4'hB, 1'b1, 1'b0, 3'd5, 1'b0);
        end
        check_val("sat_corr", 32'(corr_cnt), 32'd3);
        // Clear in the same cycle as a corrected delivery.
        run_word(7'h45, 1'b0, 4'hB, 1'b1, 1'b0, 3'd5, 1'b1);
        check_val("clr_prio", 32'(corr_cnt), 32'd0);

        // Reset mid-stream discards the in-flight word.
        @(negedge clk);
        in_valid     = 1'b1;
        codeword     = 7'h45;
        extra_parity = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_ov", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_mid_ov2", 32'(out_valid), 32'd0);
        check_val("rst_mid_cnt", 32'(corr_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecc_hamming_secded_pipe_decoder.md
# ecc_hamming_secded_pipe_decoder

Pipelined, parameterized Hamming SECDED decoder with valid/ready handshakes and saturating error-statistics counters. It is the receive-side counterpart of `ecc_hamming_encoder`: it takes a codeword plus extra parity, corrects single-bit errors, and flags double-bit errors. It sits between a storage/link read path and the consumer, where it replaces the combinational `ecc_hamming_74_decoder` when registered timing and flow control are required.

## Interface
Parameters:
- `D`, 4, data width.
- `C`, 7, codeword width; `P = C - D` parity bits, with `2**P >= C + 1`.
- `CNT_W`, 16, width of each statistics counter.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input word is valid.
- `in_ready`  out  1  decoder accepts the input word this cycle.
- `codeword`  in  C  received codeword.
- `extra_parity`  in  1  received overall parity bit.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `dout`  out  D  data, corrected when possible.
- `error_single_bit`  out  1  a single error was detected and corrected.
- `error_double_bit`  out  1  an uncorrectable error was detected.
- `syndrome`  out  P  raw syndrome.
- `cnt_clear`  in  1  synchronously zeroes both counters.
- `corr_cnt`  out  CNT_W  count of corrected words delivered.
- `uncorr_cnt`  out  CNT_W  count of uncorrectable words delivered.

## Operation
- **Bit layout, identical to `ecc_hamming_encoder`:**
  - Hamming positions 1..C map to `codeword[pos-1]`.
  - Parity bits sit at power-of-two positions.
  - Data bits fill the remaining positions in ascending order, with `din[0]` at position 3.
  - `extra_parity` is the XOR of all C codeword bits (even parity).
- **Syndrome.** `syndrome` is the XOR of the position indices of all set codeword bits. `overall = ^codeword ^ extra_parity`.
- **Classification:**
  - `overall=0`, `syndrome=0`: no error.
  - `overall=1`, `syndrome=0`: the extra parity bit is in error. Assert `error_single_bit`; data is unchanged.
  - `overall=1`, `1 <= syndrome <= C`: flip position `syndrome` and assert `error_single_bit`.
  - `overall=1`, `syndrome > C`: assert `error_double_bit`; data is uncorrected. This case can only occur when C is not full.
  - `overall=0`, `syndrome != 0`: assert `error_double_bit`; data is uncorrected.
- **Flags.** `error_single_bit` and `error_double_bit` are never asserted together.
- **Counters.** They increment on the output handshake (`out_valid && out_ready`) according to the flag of the delivered word.
  - Both counters saturate at `2**CNT_W-1`.
  - `cnt_clear` takes priority over a same-cycle increment; the result is 0.

## Timing
- **Pipeline:**
  - Stage 1 registers the codeword, `syndrome` and `overall`.
  - Stage 2 registers `dout`, the flags and `syndrome`.
  - Latency is 2 cycles from input handshake to `out_valid`, with throughput of 1 word per cycle.
- **Handshake:**
  - `s1_adv = !s2_valid || out_ready`.
  - `in_ready = !s1_valid || s1_adv`.
  - Ready paths are combinational and no data bubble is inserted.
- **Flow control:**
  - Output payload is held stable while `out_valid && !out_ready`.
  - Input is consumed only when `in_valid && in_ready`.
  - Words are never dropped or duplicated, and order is preserved.
- **Reset:**
  - All valids, `dout`, flags, `syndrome` and counters are 0.
  - `in_ready` is 1 in the first cycle after reset.
  - Reset mid-stream discards all in-flight words.
- **Full condition.** Both stages full with `out_ready=0` gives `in_ready=0`. Asserting `out_ready` in that cycle lets a new word enter in the same cycle.

## Structure
- **Package `ecc_hamming_pkg`** holds:
  - function `parity_bits(D)`;
  - function `is_pow2(pos)`;
  - function `data_pos(i)`, which maps data index to Hamming position;
  - a shared `syndrome_calc` helper. The encoder reuses all of these.
- **Sub-module `ecc_hamming_syndrome`** is combinational. It takes `codeword` and `extra_parity` and produces `syndrome` and `overall`, and is instantiated in stage 1.
- **Top level** contains the pipeline registers, correction mux, handshake logic and counters.

## Test plan
All values use D=4, C=7. Clean codeword for `din=4'hB` is `7'h55`, with extra parity 0.
- **Clean word:** `7'h55`, ep=0, `out_ready=1` → 2 cycles later `dout=4'hB`, both flags 0, `syndrome=0`.
- **Single error:** `7'h45` (position 5 flipped), ep=0 → `dout=4'hB`, `error_single_bit=1`, `syndrome=5`, `corr_cnt=1`.
- **Double error:** `7'h56` (positions 1 and 2 flipped), ep=0 → `error_double_bit=1`, `syndrome=3`, `dout=4'hB` (uncorrected), `uncorr_cnt=1`.
- **Extra parity error:** `7'h55`, ep=1 → `error_single_bit=1`, `syndrome=0`, `dout=4'hB`.
- **Backpressure:** hold `out_ready=0` and stream 3 words.
  - Required: 2 words are accepted, then `in_ready=0`.
  - Required: after `out_ready=1`, all 3 words exit in order with stable payloads.
- **Counter saturation and clear:** with `CNT_W=2`, deliver 5 single-error words.
  - Required: `corr_cnt=3`.
  - Then assert `cnt_clear` in the same cycle as a delivered single-error word. Required: `corr_cnt=0`.
